// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing and pattern blocks.
// Holds the 640x480@60 default timing, the pattern mode encoding and the
// width used for the pixel and line counters.
package vga_pkg;

  // Width of the pixel and line counters. It also bounds the totals (2047).
  localparam int CNT_W   = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Default 640x480 timing, in pixel clocks and lines.
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  typedef enum logic [1:0] {
    VGA_MODE_BARS  = 2'd0,
    VGA_MODE_CHECK = 2'd1,
    VGA_MODE_GRAD  = 2'd2,
    VGA_MODE_BLACK = 2'd3
  } vga_mode_e;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
// It is a wrapping counter with a terminal-count pulse. The valid and sync
// flags are decoded combinationally from the count, and the caller registers them.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VIS      = DEF_H_VIS,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             valid,
  output logic             sync
);

  localparam int TOT = VIS + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VIS + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VIS + FP + SYNC);

  // Advance when enabled and wrap to zero after the last position.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)   cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + CNT_W'(1);
  end

  assign tc    = en && (cnt == LAST);
  assign valid = (cnt < VIS_END);
  assign sync  = ((cnt >= SYNC_LO) && (cnt < SYNC_HI)) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern generator.
// Every output is registered one stage behind the internal counters. As a
// result, hcnt/vcnt always name the pixel that the sync, valid and colour
// outputs describe.
// Optional feature, macro VGA_PATTERN_SCROLL_EN: the checkerboard and
// gradient patterns scroll horizontally by one pixel per frame.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int CW       = 4,
  parameter int CHK_LOG2 = 4
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic [1:0]       mode,
  output logic             hsync,
  output logic             vsync,
  output logic             hvalid,
  output logic             vvalid,
  output logic [CW-1:0]    r,
  output logic [CW-1:0]    g,
  output logic [CW-1:0]    b,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = H_VIS / 8;
  localparam bit POL   = (SYNC_POL != 0);

  // Reject configurations the counters or the pattern logic cannot represent.
  if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_total
    $error("vga_pattern_gen: H_TOT and V_TOT must not exceed 2047");
  end
  if (H_VIS % 8 != 0) begin : g_bad_hvis
    $error("vga_pattern_gen: H_VIS must be a multiple of 8");
  end
  if (CW < 1 || CW > 8) begin : g_bad_cw
    $error("vga_pattern_gen: CW must be in 1..8");
  end
  if (CHK_LOG2 < 0 || CHK_LOG2 > CNT_W - 1) begin : g_bad_chk
    $error("vga_pattern_gen: CHK_LOG2 must be in 0..10");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt, pat_x;
  logic             h_tc, v_tc, h_valid, v_valid, h_sync, v_sync;
  logic             origin;
  vga_mode_e        mode_q, mode_eff;
  logic [2:0]       bar;
  logic [3*CW-1:0]  pix_rgb;

  vga_axis_counter #(
    .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(POL)
  ) u_h (
    .clk(clk), .RSTn(RSTn), .en(1'b1),
    .cnt(h_cnt), .tc(h_tc), .valid(h_valid), .sync(h_sync)
  );

  vga_axis_counter #(
    .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(POL)
  ) u_v (
    .clk(clk), .RSTn(RSTn), .en(h_tc),
    .cnt(v_cnt), .tc(v_tc), .valid(v_valid), .sync(v_sync)
  );

  // Flag the cycle in which the internal counters sit at (0,0). The flag is
  // set out of reset and again whenever the frame wraps.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) origin <= 1'b1;
    else       origin <= v_tc;
  end

  // Latch the pattern selection only at the frame origin.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)       mode_q <= VGA_MODE_BARS;
    else if (origin) mode_q <= vga_mode_e'(mode);
  end

  // At the origin the newly sampled mode already applies to pixel (0,0).
  assign mode_eff = origin ? vga_mode_e'(mode) : mode_q;

`ifdef VGA_PATTERN_SCROLL_EN
  logic [CNT_W-1:0] frame_cnt;

  // Count frames. The count advances as the counters wrap back to (0,0), so
  // frame N after reset is drawn with an offset of N.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)     frame_cnt <= '0;
    else if (v_tc) frame_cnt <= frame_cnt + CNT_W'(1);
  end

  assign pat_x = h_cnt + frame_cnt;
`else
  assign pat_x = h_cnt;
`endif

  // Colour-bar index from a comparator chain on the unscrolled x position.
  // NOTE: give every always_comb output a default first, so no latch is inferred.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= CNT_W'(i * BAR_W)) bar = 3'(i);
    end
  end

  function automatic logic [3*CW-1:0] pattern_rgb(
    input vga_mode_e        m,
    input logic [CNT_W-1:0] px,
    input logic [CNT_W-1:0] py,
    input logic [2:0]       k
  );
    logic [CW-1:0] cr, cg, cb;
    cr = '0;
    cg = '0;
    cb = '0;
    case (m)
      VGA_MODE_BARS: begin
        cr = {CW{k[2]}};
        cg = {CW{k[1]}};
        cb = {CW{k[0]}};
      end
      VGA_MODE_CHECK: begin
        cr = {CW{px[CHK_LOG2] ^ py[CHK_LOG2]}};
        cg = cr;
        cb = cr;
      end
      VGA_MODE_GRAD: begin
        cr = px[9 -: CW];
        cg = py[9 -: CW];
      end
      default: ;
    endcase
    return {cr, cg, cb};
  endfunction

  assign pix_rgb = pattern_rgb(mode_eff, pat_x, v_cnt, bar);

  // Register all outputs from the same counter state so that they stay aligned.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      hvalid      <= 1'b0;
      vvalid      <= 1'b0;
      frame_start <= 1'b0;
      {r, g, b}   <= '0;
    end else begin
      hcnt        <= h_cnt;
      vcnt        <= v_cnt;
      hsync       <= h_sync;
      vsync       <= v_sync;
      hvalid      <= h_valid;
      vvalid      <= v_valid;
      frame_start <= origin;
      {r, g, b}   <= (h_valid && v_valid) ? pix_rgb : '0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: self-checking bench for vga_pattern_gen.
// Instance A uses the small timing (24x12 totals, CW=8). Instance B uses a
// 640-pixel line with short porches and a 20-line frame (CW=4). A reference
// model predicts each instance's outputs from the number of clocks since
// reset and from the mode sampled at each frame start.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  localparam int A_HV = 16, A_HF = 2, A_HS = 3, A_HB = 3;
  localparam int A_VV = 8,  A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int A_CW = 8,  A_CHK = 2;
  localparam int A_FR = (A_HV + A_HF + A_HS + A_HB) * (A_VV + A_VF + A_VS + A_VB);
  localparam int B_HV = 640, B_HF = 8, B_HS = 8, B_HB = 8;
  localparam int B_VV = 20,  B_VF = 1, B_VS = 2, B_VB = 1;
  localparam int B_CW = 4,   B_CHK = 4;
  localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
  localparam int B_FR = B_HT * (B_VV + B_VF + B_VS + B_VB);
`ifdef VGA_PATTERN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  typedef struct packed {
    logic       hs, vs, hv, vv, fs;
    logic [10:0] x, y;
    logic [7:0]  r, g, b;
  } pix_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  logic hsync_a, vsync_a, hvalid_a, vvalid_a, fs_a;
  logic hsync_b, vsync_b, hvalid_b, vvalid_b, fs_b;
  logic [A_CW-1:0] r_a, g_a, b_a;
  logic [B_CW-1:0] r_b, g_b, b_b;
  logic [10:0] hcnt_a, vcnt_a, hcnt_b, vcnt_b;

  int tests = 0;
  int fails = 0;
  int pix_a, pix_b, mode_eff_a, mode_eff_b;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_VIS(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_VIS(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .SYNC_POL(0), .CW(A_CW), .CHK_LOG2(A_CHK)
  ) u_dut_a (
    .clk(clk), .RSTn(rst_a), .mode(mode_a),
    .hsync(hsync_a), .vsync(vsync_a), .hvalid(hvalid_a), .vvalid(vvalid_a),
    .r(r_a), .g(g_a), .b(b_a), .hcnt(hcnt_a), .vcnt(vcnt_a), .frame_start(fs_a)
  );

  vga_pattern_gen #(
    .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .SYNC_POL(0), .CW(B_CW), .CHK_LOG2(B_CHK)
  ) u_dut_b (
    .clk(clk), .RSTn(rst_b), .mode(mode_b),
    .hsync(hsync_b), .vsync(vsync_b), .hvalid(hvalid_b), .vvalid(vvalid_b),
    .r(r_b), .g(g_b), .b(b_b), .hcnt(hcnt_b), .vcnt(vcnt_b), .frame_start(fs_b)
  );

  // Model state: pixel index since reset release (-1 while in reset), plus
  // the mode that was present at each frame start.
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      pix_a <= -1;
      mode_eff_a <= 0;
    end else begin
      pix_a <= pix_a + 1;
      if ((pix_a + 1) % A_FR == 0) mode_eff_a <= int'(mode_a);
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pix_b <= -1;
      mode_eff_b <= 0;
    end else begin
      pix_b <= pix_b + 1;
      if ((pix_b + 1) % B_FR == 0) mode_eff_b <= int'(mode_b);
    end
  end

  // Expected outputs for pixel number pix. Sync is active-low.
  function automatic pix_t model(input int hv, hf, hs, hb, vv, vf, vs, vb,
                                 input int cw, chk, pix, m);
    pix_t e;
    int ht, vt, p, x, y, fr, xp, k, mask, c;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (pix < 0) return e;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    p  = pix % (ht * vt);
    x  = p % ht;
    y  = p / ht;
    fr = (pix / (ht * vt)) % 2048;
    e.x  = 11'(x);
    e.y  = 11'(y);
    e.fs = (p == 0);
    e.hs = !(x >= hv + hf && x < hv + hf + hs);
    e.vs = !(y >= vv + vf && y < vv + vf + vs);
    e.hv = (x < hv);
    e.vv = (y < vv);
    mask = (1 << cw) - 1;
    xp = (SCROLL && (m == 1 || m == 2)) ? (x + fr) % 2048 : x;
    if (e.hv && e.vv) begin
      case (m)
        0: begin
          k = x / (hv / 8);
          e.r = 8'(((k >> 2) & 1) * mask);
          e.g = 8'(((k >> 1) & 1) * mask);
          e.b = 8'((k & 1) * mask);
        end
        1: begin
          c = (((xp >> chk) ^ (y >> chk)) & 1) * mask;
          e.r = 8'(c);
          e.g = 8'(c);
          e.b = 8'(c);
        end
        2: begin
          e.r = 8'((xp >> (10 - cw)) & mask);
          e.g = 8'((y >> (10 - cw)) & mask);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic pix_t exp_a();
    return model(A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_CW, A_CHK, pix_a, mode_eff_a);
  endfunction

  function automatic pix_t exp_b();
    return model(B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_CW, B_CHK, pix_b, mode_eff_b);
  endfunction

  function automatic pix_t got_a();
    pix_t p;
    p.hs = hsync_a; p.vs = vsync_a; p.hv = hvalid_a; p.vv = vvalid_a; p.fs = fs_a;
    p.x = hcnt_a; p.y = vcnt_a;
    p.r = 8'(r_a); p.g = 8'(g_a); p.b = 8'(b_a);
    return p;
  endfunction

  function automatic pix_t got_b();
    pix_t p;
    p.hs = hsync_b; p.vs = vsync_b; p.hv = hvalid_b; p.vv = vvalid_b; p.fs = fs_b;
    p.x = hcnt_b; p.y = vcnt_b;
    p.r = 8'(r_b); p.g = 8'(g_b); p.b = 8'(b_b);
    return p;
  endfunction

  // Apply a reset pulse with mode m set up. Returns at a negedge just after release.
  task automatic reset_a(input logic [1:0] m);
    mode_a = m; rst_a = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic reset_b(input logic [1:0] m);
    mode_b = m; rst_b = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests++;
    if (got_a() !== pix_t'({5'b11000, 22'd0, 24'd0})) begin
      fails++; $display("FAIL reset_a got=%h exp=%h", got_a(), pix_t'({5'b11000, 22'd0, 24'd0}));
    end
    tests++;
    if (got_b() !== exp_b()) begin
      fails++; $display("FAIL reset_b got=%h exp=%h", got_b(), exp_b());
    end
  endtask

  task automatic test_small_timing();
    int cnt, vmin, vmax, hmin, hmax;
    bit seen;
    reset_a(2'd0);
    for (int n = 0; n < 2 * A_FR; n++) begin
      @(negedge clk);
      tests++;
      if (got_a() !== exp_a()) begin
        fails++; $display("FAIL small_pixel pix=%0d got=%h exp=%h", pix_a, got_a(), exp_a());
      end
    end
    // Period of frame_start, in clocks.
    cnt = 0;
    while (!fs_a && cnt < 400) begin @(negedge clk); cnt++; end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!fs_a && cnt < 400);
    tests++;
    if (cnt != 288) begin fails++; $display("FAIL frame_period got=%0d exp=288", cnt); end
    // hsync low width, starting at hcnt 18.
    cnt = 0;
    while (hcnt_a != 11'd18 && cnt < 50) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (!hsync_a && cnt < 10) begin @(negedge clk); cnt++; end
    tests++;
    if (cnt != 3) begin fails++; $display("FAIL hsync_width got=%0d exp=3", cnt); end
    // Lines with vsync low, and hcnt range with hvalid high, over one frame.
    vmin = 99; vmax = -1; hmin = 99; hmax = -1; seen = 1'b0;
    for (int n = 0; n < A_FR; n++) begin
      @(negedge clk);
      if (!vsync_a) begin
        vmin = (int'(vcnt_a) < vmin) ? int'(vcnt_a) : vmin;
        vmax = (int'(vcnt_a) > vmax) ? int'(vcnt_a) : vmax;
      end
      if (hvalid_a) begin
        seen = 1'b1;
        hmin = (int'(hcnt_a) < hmin) ? int'(hcnt_a) : hmin;
        hmax = (int'(hcnt_a) > hmax) ? int'(hcnt_a) : hmax;
      end
    end
    tests++;
    if (vmin != 9 || vmax != 10) begin
      fails++; $display("FAIL vsync_lines got=%0d..%0d exp=9..10", vmin, vmax);
    end
    tests++;
    if (!seen || hmin != 0 || hmax != 15) begin
      fails++; $display("FAIL hvalid_range got=%0d..%0d exp=0..15", hmin, hmax);
    end
  endtask

  task automatic test_bars();
    reset_b(2'd0);
    for (int n = 0; n <= B_HT; n++) begin
      @(negedge clk);
      tests++;
      if (got_b() !== exp_b()) begin
        fails++; $display("FAIL bars_pixel pix=%0d got=%h exp=%h", pix_b, got_b(), exp_b());
      end
      if (pix_b == 0 || pix_b == 80 || pix_b == 639 || pix_b == 640) begin
        tests++;
        if ({r_b, g_b, b_b} !== ((pix_b == 80) ? 12'h00F : (pix_b == 639) ? 12'hFFF : 12'h000)) begin
          fails++; $display("FAIL bars_x%0d got=%h", pix_b, {r_b, g_b, b_b});
        end
      end
    end
  endtask

  task automatic test_checker();
    reset_b(2'd1);
    for (int n = 0; n <= 16 * B_HT + 16; n++) begin
      @(negedge clk);
      tests++;
      if (got_b() !== exp_b()) begin
        fails++; $display("FAIL check_pixel pix=%0d got=%h exp=%h", pix_b, got_b(), exp_b());
      end
      if (pix_b == 16) begin
        tests++;
        if ({r_b, g_b, b_b} !== 12'hFFF) begin
          fails++; $display("FAIL check_16_0 got=%h exp=fff", {r_b, g_b, b_b});
        end
      end
      if (pix_b == 16 * B_HT + 16) begin
        tests++;
        if ({r_b, g_b, b_b} !== 12'h000) begin
          fails++; $display("FAIL check_16_16 got=%h exp=000", {r_b, g_b, b_b});
        end
      end
    end
  endtask

  task automatic test_gradient();
    reset_b(2'd2);
    for (int n = 0; n < 2 * B_HT; n++) begin
      @(negedge clk);
      tests++;
      if (got_b() !== exp_b()) begin
        fails++; $display("FAIL grad_pixel pix=%0d got=%h exp=%h", pix_b, got_b(), exp_b());
      end
      if (pix_b == 320) begin
        tests++;
        if ({r_b, g_b, b_b} !== 12'h500) begin
          fails++; $display("FAIL grad_320 got=%h exp=500", {r_b, g_b, b_b});
        end
      end
    end
  endtask

  // Mode switch mid-frame: bars persist until the next frame start.
  task automatic test_mode_change();
    reset_a(2'd0);
    for (int n = 0; n < 2 * A_FR; n++) begin
      @(negedge clk);
      tests++;
      if (got_a() !== exp_a()) begin
        fails++; $display("FAIL change_pixel pix=%0d got=%h exp=%h", pix_a, got_a(), exp_a());
      end
      if (pix_a == 6 * 24 + 4) begin
        tests++;
        if ({r_a, g_a, b_a} !== 24'h00FF00) begin
          fails++; $display("FAIL change_old got=%h exp=00ff00", {r_a, g_a, b_a});
        end
      end
      if (pix_a == A_FR + 4) begin
        tests++;
        if ({r_a, g_a, b_a} !== 24'hFFFFFF) begin
          fails++; $display("FAIL change_new got=%h exp=ffffff", {r_a, g_a, b_a});
        end
      end
      if (pix_a == 5 * 24) mode_a = 2'd1;
    end
  endtask

  task automatic test_reset_midframe();
    reset_a(2'd1);
    repeat (5 * 24 + 7) @(negedge clk);
    @(posedge clk); #2;
    rst_a = 1'b0;
    #1;
    tests++;
    if (got_a() !== pix_t'({5'b11000, 22'd0, 24'd0})) begin
      fails++; $display("FAIL midreset got=%h", got_a());
    end
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    tests++;
    if (hcnt_a !== 11'd0 || vcnt_a !== 11'd0 || fs_a !== 1'b1) begin
      fails++; $display("FAIL after_reset got x=%0d y=%0d fs=%b exp 0 0 1", hcnt_a, vcnt_a, fs_a);
    end
    tests++;
    if (got_a() !== exp_a()) begin
      fails++; $display("FAIL after_reset_pixel got=%h exp=%h", got_a(), exp_a());
    end
  endtask

  task automatic test_random_modes();
    reset_a(2'($urandom_range(0, 3)));
    for (int n = 0; n < 30 * A_FR; n++) begin
      @(negedge clk);
      tests++;
      if (got_a() !== exp_a()) begin
        fails++; $display("FAIL random_pixel pix=%0d got=%h exp=%h", pix_a, got_a(), exp_a());
      end
      if ($urandom_range(0, 99) == 0) mode_a = 2'($urandom_range(0, 3));
    end
  endtask

`ifdef VGA_PATTERN_SCROLL_EN
  task automatic test_scroll();
    reset_a(2'd2);
    for (int n = 0; n <= 64 * A_FR; n++) begin
      @(negedge clk);
      tests++;
      if (got_a() !== exp_a()) begin
        fails++; $display("FAIL scroll_pixel pix=%0d got=%h exp=%h", pix_a, got_a(), exp_a());
      end
      // CW=8 gives r = x[9:2]: frame 3 -> 0, frame 64 -> 16.
      if (pix_a == 3 * A_FR || pix_a == 64 * A_FR) begin
        tests++;
        if (r_a !== ((pix_a == 3 * A_FR) ? 8'd0 : 8'd16)) begin
          fails++; $display("FAIL scroll_r pix=%0d got=%0d", pix_a, r_a);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_small_timing();
    test_bars();
    test_checker();
    test_gradient();
    test_mode_change();
    test_reset_midframe();
    test_random_modes();
`ifdef VGA_PATTERN_SCROLL_EN
    test_scroll();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator. It is the configurable successor to the fixed 640x480 `vga` block. It produces hsync/vsync, the active-video qualifiers, pixel coordinates and a selectable RGB test pattern at a configurable colour depth. It sits between the pixel clock domain and the DAC/pin drivers and is the default pixel source for board bring-up and display-path benches.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, sync active level: 0 = active-low, 1 = active-high
- `CW`, 4, bits per colour channel (1..8)
- `CHK_LOG2`, 4, checkerboard cell size is 2^CHK_LOG2 pixels

Ports:
- `clk` in 1: pixel clock
- `RSTn` in 1: asynchronous, active-low reset
- `mode` in 2: pattern select (0 colour bars, 1 checkerboard, 2 gradient, 3 black)
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `hvalid` out 1: horizontal active region
- `vvalid` out 1: vertical active region
- `r`, `g`, `b` out CW each: pixel colour
- `hcnt` out 11: pixel x of current output
- `vcnt` out 11: line y of current output
- `frame_start` out 1: one-cycle pulse when output is at (0,0)

## Operation
- `H_TOT = H_VIS+H_FP+H_SYNC+H_BP`; `V_TOT` is defined likewise. Elaboration fails if either exceeds 2047, if `H_VIS` is not a multiple of 8, or if `CW` is outside 1..8.
- The internal h counter counts 0..H_TOT-1 and wraps. The v counter increments on each h wrap, counts 0..V_TOT-1 and wraps.
- Horizontal regions: visible [0,H_VIS); sync [H_VIS+H_FP, H_VIS+H_FP+H_SYNC). Vertical regions follow the same scheme in lines.
- `hsync`/`vsync` equal `SYNC_POL` inside the sync region and `~SYNC_POL` elsewhere.
- `hvalid` = x<H_VIS; `vvalid` = y<V_VIS.
- Patterns (x = pattern coordinate, y = vcnt):
  - Mode 0, colour bars: bar index k = x/(H_VIS/8). Implement with a comparator chain, no divider. r/g/b = replicate k[2]/k[1]/k[0] across CW bits.
  - Mode 1, checkerboard: all channels = replicate (x[CHK_LOG2]^y[CHK_LOG2]).
  - Mode 2, gradient: r = x[9 -: CW], g = y[9 -: CW], b = 0.
  - Mode 3: black.
- r/g/b are forced to 0 whenever !(hvalid&&vvalid).
- `mode` is sampled into `mode_q` only on the edge where the internal counter is (0,0). Mid-frame changes take effect from the next frame. `mode_q` is 0 after reset.

## Timing
- Reset values: `hcnt`=0, `vcnt`=0, `hsync`=`vsync`=~SYNC_POL, `hvalid`=`vvalid`=0, `r`/`g`/`b`=0, `frame_start`=0. Internal counters = 0, `mode_q`=0.
- All outputs are registered, one stage behind the internal counters. `hcnt`/`vcnt` are the pipelined copies, so every output is mutually aligned: at any cycle, sync/valid/rgb describe pixel (`hcnt`,`vcnt`).
- First rising edge after RSTn deasserts: outputs show (0,0) with `frame_start`=1, the internal counter becomes (1,0), and `mode_q` captures `mode`.
- `frame_start` pulses once every H_TOT*V_TOT cycles.
- Reset asserted mid-frame clears everything asynchronously. Counting restarts from (0,0).

## Configuration
- `VGA_PATTERN_SCROLL_EN` defined:
  - An 11-bit frame counter increments on each internal (0,0) and is cleared by reset.
  - The pattern coordinate is x = hcnt + frame counter, modulo 2048, for modes 1 and 2 only. Mode 0 is unaffected.
- Not defined: x = hcnt and no frame-counter flops exist.

## Structure
- Shared package `vga_pkg`: 640x480 default timing localparams, the mode enum (`VGA_MODE_BARS`, `VGA_MODE_CHECK`, `VGA_MODE_GRAD`, `VGA_MODE_BLACK`), and the count width constant (11).
- One sub-module, `vga_axis_counter`: wrapping counter with terminal-count pulse, plus valid/sync decode from (VIS, FP, SYNC, BP) parameters. It is instantiated once for h and once for v, with the v instance enabled by the h terminal count.

## Test plan
- Small timing (H 16/2/3/3, V 8/1/2/1, CW=4): checks counter sequencing and the outputs produced at (0,0) and at each sync and valid region edge.
  - `frame_start` period must be 288 clocks.
  - `hsync` must be low for exactly 3 clocks from `hcnt`=18.
  - `vsync` must be low for lines 9–10.
  - `hvalid` must be high only for `hcnt` 0–15.
- Mode 0 at default timing: `hcnt`=0 gives rgb=(0,0,0); `hcnt`=80 gives (0,0,F); `hcnt`=639 gives (F,F,F); `hcnt`=640 gives 0.
- Mode 1, then mode 2:
  - Mode 1 at (16,0) → all F, and at (16,16) → 0.
  - Mode 2 at (320,240) → r=5, g=3, b=0.
- Mode changed 0→1 at line 100: output stays bars until the next `frame_start`, then becomes checkerboard from pixel (0,0).
- RSTn pulsed low at line 200: all outputs take their reset values immediately. After release the first output is (0,0) with `frame_start`=1.
- With `VGA_PATTERN_SCROLL_EN`, mode 2, frame 3: pixel (0,0) has r=0 (x=3). At frame 64, `hcnt`=0 gives r=1.
